// File: rtl/bus_pkg.sv
// Shared definitions for the bus transfer controller.
//   - FSM state encoding (enum plus width)
//   - default sizing for driver count, destination count and data width
//   - idx_w(): index width for an N-entry select (never below 1 bit)
package bus_pkg;

  localparam int unsigned N_SRC_DEF = 4;
  localparam int unsigned N_DST_DEF = 4;
  localparam int unsigned W_DEF     = 8;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_TURN  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_LOAD  = 2'd3
  } state_e;

  // Index width for an n-way select; a single entry still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_onehot_dec.sv
// Index-to-one-hot decoder with enable gate (combinational).
//   en       : gate; all outputs 0 when low
//   idx      : index to decode; indices >= N decode to all-zero
//   onehot_c : one-hot-or-zero result
module bus_onehot_dec #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic          en,
  input  logic [IW-1:0] idx,
  output logic [N-1:0]  onehot_c
);

  always_comb begin
    onehot_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (en && (32'(idx) == i)) onehot_c[i] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Shared-bus transfer controller: sequences IDLE -> TURN -> DRIVE -> LOAD so
// that a tri-state driver is enabled only after a dead (turnaround) cycle and
// the destination register loads while the driver is still on the bus.
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/src/dst   : transfer request (accepted when req_ready=1)
//   abort               : cancel an in-flight transfer (ignored in IDLE)
//   bus_data            : resolved bus value, captured at the end of LOAD
//   req_ready           : high in IDLE
//   drv_en, ld_en       : one-hot-or-zero driver enables / load strobes
//   data_out            : last captured bus value
//   done, err           : one-cycle completion / rejection pulses
module bus_xfer_ctrl
  import bus_pkg::*;
#(
  parameter int unsigned N_SRC = N_SRC_DEF,
  parameter int unsigned N_DST = N_DST_DEF,
  parameter int unsigned W     = W_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  input  logic [idx_w(N_SRC)-1:0]     req_src,
  input  logic [idx_w(N_DST)-1:0]     req_dst,
  input  logic                        abort,
  input  logic [W-1:0]                bus_data,
  output logic                        req_ready,
  output logic [N_SRC-1:0]            drv_en,
  output logic [N_DST-1:0]            ld_en,
  output logic [W-1:0]                data_out,
  output logic                        done,
  output logic                        err
);

  localparam int unsigned SW = idx_w(N_SRC);
  localparam int unsigned DW = idx_w(N_DST);

  localparam logic [STATE_W-1:0] S_IDLE  = ST_IDLE;
  localparam logic [STATE_W-1:0] S_TURN  = ST_TURN;
  localparam logic [STATE_W-1:0] S_DRIVE = ST_DRIVE;
  localparam logic [STATE_W-1:0] S_LOAD  = ST_LOAD;

  logic [STATE_W-1:0] state_q, state_nxt;
  logic [SW-1:0]      src_q, src_nxt;
  logic [DW-1:0]      dst_q, dst_nxt;
  logic               accept_c, bad_c;
  logic               err_nxt, done_nxt;
  logic               drv_on_c, ld_on_c;
  logic [N_SRC-1:0]   drv_dec_c;
  logic [N_DST-1:0]   ld_dec_c;

  // Request qualification: out-of-range index or self-transfer is rejected.
  assign accept_c = req_valid && req_ready;
  assign bad_c    = (32'(req_src) >= N_SRC) || (32'(req_dst) >= N_DST) ||
                    (32'(req_src) == 32'(req_dst));

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state_q;
    src_nxt   = src_q;
    dst_nxt   = dst_q;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          src_nxt = req_src;
          dst_nxt = req_dst;
          if (bad_c) err_nxt   = 1'b1;
          else       state_nxt = S_TURN;
        end
      end
      S_TURN:  state_nxt = abort ? S_IDLE : S_DRIVE;
      S_DRIVE: state_nxt = abort ? S_IDLE : S_LOAD;
      S_LOAD: begin
        state_nxt = S_IDLE;
        done_nxt  = !abort;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Enables are decoded from the next state so they come straight off flops.
  assign drv_on_c = (state_nxt == S_DRIVE) || (state_nxt == S_LOAD);
  assign ld_on_c  = (state_nxt == S_LOAD);

  bus_onehot_dec #(.N(N_SRC), .IW(SW)) u_drv_dec (
    .en       (drv_on_c),
    .idx      (src_nxt),
    .onehot_c (drv_dec_c)
  );

  bus_onehot_dec #(.N(N_DST), .IW(DW)) u_ld_dec (
    .en       (ld_on_c),
    .idx      (dst_nxt),
    .onehot_c (ld_dec_c)
  );

  // State and registered outputs; reset drops every enable at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      req_ready <= 1'b0;
      drv_en    <= '0;
      ld_en     <= '0;
      data_out  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      src_q     <= src_nxt;
      dst_q     <= dst_nxt;
      req_ready <= (state_nxt == S_IDLE);
      drv_en    <= drv_dec_c;
      ld_en     <= ld_dec_c;
      done      <= done_nxt;
      err       <= err_nxt;
      if (done_nxt) data_out <= bus_data;
    end
  end

endmodule
